// File: rtl/riscv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : riscv_pkg
// Purpose  : Shared RV32I opcodes and the hazard sequencer state encoding.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_S    = 7'b0100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_B    = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_HALT = 7'b1111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  // Pipeline register enable/flush bundle, in pipeline order.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_write;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE = '0;
  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : load_use_detect
// Purpose  : Flags an ID instruction that reads the destination of a load in EX.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module load_use_detect
  import riscv_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  output logic       load_use_o
);

  logic w_rs1_match;
  logic w_rs2_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign w_rs1_match = (ex_rd_i == id_rs1_i);
  assign w_rs2_match = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign load_use_o  = ex_mem_read_i && (ex_rd_i != 5'd0) && (w_rs1_match || w_rs2_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipeline_hazard_sequencer
// Purpose  : Stall/flush/memory-wait/halt-drain sequencing for a 5-stage RV32I pipe.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module pipeline_hazard_sequencer
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       id_halt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_redirect,
  input  logic       mem_valid,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_flush,
  output logic       ex_mem_write,
  output logic       mem_wb_write,
  output logic       halted,
  output logic       mem_error
);

  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_drain_last = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic              halted_q, halted_d;
  logic              mem_error_q, mem_error_d;

  logic              w_mem_wait;
  logic              w_load_use;
  pipe_ctrl_t        w_ctrl;

  assign w_mem_wait = mem_valid && !mem_ready;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (w_load_use)
  );

  always_comb begin
    w_ctrl = CTRL_FREEZE;
    unique case (state_q)
      RUN: begin
        if (!w_mem_wait) begin
          w_ctrl = CTRL_RUN;
          // The ID instruction is on the wrong path after a redirect, so its
          // load-use or halt is dropped along with it.
          if (ex_redirect) begin
            w_ctrl.if_id_flush = 1'b1;
            w_ctrl.id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_write = 1'b0;
            w_ctrl.id_ex_flush = 1'b1;
          end else if (id_halt) begin
            w_ctrl.pc_write    = 1'b0;
            w_ctrl.if_id_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!w_mem_wait) begin
          w_ctrl             = CTRL_RUN;
          w_ctrl.pc_write    = 1'b0;
          w_ctrl.if_id_flush = 1'b1;
        end
      end
      default: w_ctrl = CTRL_FREEZE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    mem_error_d = mem_error_q;
    if (state_q != HALTED) begin
      if (w_mem_wait) begin
        if (wait_cnt_q == c_timeout) begin
          mem_error_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = HALTED;
        end else begin
          wait_cnt_d = wait_cnt_q + c_one;
        end
      end else begin
        wait_cnt_d = '0;
        if (state_q == RUN) begin
          if (!ex_redirect && !w_load_use && id_halt) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end else if (drain_cnt_q == c_drain_last) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + c_one;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Enables are forced low for the whole time reset is asserted, not just at the edge.
  assign pc_write     = rst_n && w_ctrl.pc_write;
  assign if_id_write  = rst_n && w_ctrl.if_id_write;
  assign if_id_flush  = rst_n && w_ctrl.if_id_flush;
  assign id_ex_write  = rst_n && w_ctrl.id_ex_write;
  assign id_ex_flush  = rst_n && w_ctrl.id_ex_flush;
  assign ex_mem_write = rst_n && w_ctrl.ex_mem_write;
  assign mem_wb_write = rst_n && w_ctrl.mem_wb_write;
  assign halted       = halted_q;
  assign mem_error    = mem_error_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pipeline_hazard_sequencer
// Purpose  : Directed self-checking bench for pipeline_hazard_sequencer.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, id_halt, ex_mem_read, ex_redirect, mem_valid, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic       ex_mem_write, mem_wb_write, halted, mem_error;

  int checks   = 0;
  int failures = 0;

  // {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, halted, mem_error}
  localparam logic [8:0] V_ZERO   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_RUN    = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] V_STALL  = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] V_REDIR  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] V_DRAIN  = 9'b0_1_1_1_0_1_1_0_0;
  localparam logic [8:0] V_HALTED = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] V_MEMERR = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] M_ALL    = 9'h1FF;
  localparam logic [8:0] M_NO_HLT = 9'b1_1_1_1_1_1_1_0_1;

  logic [8:0] exp_q[$];
  logic [8:0] msk_q[$];
  string      tag_q[$];

  pipeline_hazard_sequencer #(
    .DRAIN_CYCLES (3),
    .MEM_TIMEOUT  (4),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs2  (id_uses_rs2),
    .id_halt      (id_halt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_write (ex_mem_write),
    .mem_wb_write (mem_wb_write),
    .halted       (halted),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses2,
                       input logic halt, input logic mrd, input logic [4:0] rd,
                       input logic redir, input logic mv, input logic mrdy);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses2; id_halt = halt;
    ex_mem_read = mrd; ex_rd = rd; ex_redirect = redir;
    mem_valid = mv; mem_ready = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rand_in();
    drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Push expectation for the cycle whose inputs are now applied, sample mid-cycle, compare.
  task automatic cyc(input string tag, input logic [8:0] exp, input logic [8:0] msk);
    logic [8:0] obs, e, m;
    string      t;
    exp_q.push_back(exp); msk_q.push_back(msk); tag_q.push_back(tag);
    @(negedge clk);
    obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_write, halted, mem_error};
    e = exp_q.pop_front(); m = msk_q.pop_front(); t = tag_q.pop_front();
    checks++;
    assert (((obs ^ e) & m) === 9'b0)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", t, obs & m, e & m);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_in();
    cyc("rst_hold", V_ZERO, M_ALL);
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk); #1;

    // Reset with random inputs, then release idle.
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cyc("rst_rand", V_ZERO, M_ALL);
    end
    idle(); rst_n = 1'b1;
    cyc("rst_release", V_RUN, M_ALL);

    // Load-use on rs1, then the load has moved on.
    drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc("lu_rs1", V_STALL, M_ALL);
    idle();
    cyc("lu_after", V_RUN, M_ALL);
    drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("lu_x0", V_RUN, M_ALL);
    drive(5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc("lu_rs2_unused", V_RUN, M_ALL);
    drive(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    cyc("lu_rs2_used", V_STALL, M_ALL);

    // Redirect beats load-use and halt in the same cycle; halt must not take effect.
    drive(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
    cyc("redir_lu_halt", V_REDIR, M_ALL);
    idle();
    cyc("redir_after", V_RUN, M_ALL);

    // Wait counter clears when mem_ready arrives on cycle 4.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("wait_pre", V_ZERO, M_ALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cyc("wait_ready", V_RUN, M_ALL);
    // Timeout: five consecutive wait cycles with MEM_TIMEOUT=4.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("wait_freeze", V_ZERO, M_ALL);
    idle();
    cyc("timeout_err", V_MEMERR, M_NO_HLT);
    do_reset();
    cyc("post_err_reset", V_RUN, M_ALL);

    // Halt: one ID cycle plus three drain cycles, then halted.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("halt_id", V_DRAIN, M_ALL);
    idle();
    cyc("drain0", V_DRAIN, M_ALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    cyc("drain1_redir", V_DRAIN, M_ALL);
    idle();
    cyc("drain2", V_DRAIN, M_ALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    cyc("halted_redir", V_HALTED, M_ALL);
    drive(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
    cyc("halted_ignore", V_HALTED, M_ALL);
    do_reset();
    cyc("post_halt_reset", V_RUN, M_ALL);

    // Halt with a 2-cycle memory wait during drain.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("halt5_id", V_DRAIN, M_ALL);
    idle();
    cyc("halt5_d0", V_DRAIN, M_ALL);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("halt5_wait0", V_ZERO, M_ALL);
    cyc("halt5_wait1", V_ZERO, M_ALL);
    idle();
    cyc("halt5_d1", V_DRAIN, M_ALL);
    cyc("halt5_d2", V_DRAIN, M_ALL);
    cyc("halt5_halted", V_HALTED, M_ALL);

    // Reset mid-drain returns to RUN with no stale drain state.
    do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("mid_halt_id", V_DRAIN, M_ALL);
    idle();
    cyc("mid_drain0", V_DRAIN, M_ALL);
    do_reset();
    for (int i = 0; i < 4; i++) cyc("mid_rst_run", V_RUN, M_ALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
